execution_pipe: RTL and testbench

- Parametrised successor to the single-cycle 16-bit execution stage.
- Takes a decoded operation from the register-read stage and computes a WIDTH-bit ALU result.
- Passes destination register and write-enable through to writeback.
- Adds valid/ready handshaking with backpressure, carry/zero flags, shift ops and an optional multi-cycle iterative multiplier.

---
 rtl/exec_pkg.sv | 21 ++
 rtl/exec_mul_iter.sv | 56 +++++
 rtl/execution_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_execution_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: shared definitions for the execution pipe.
//   - 3-bit ALU opcode encodings (OP_ADD .. OP_MUL)
//   - multiply-sequencer state encoding (IDLE / MUL / WB)
package exec_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StWb   = 2'd2
  } exec_state_e;

endpackage

// File: rtl/exec_mul_iter.sv
// exec_mul_iter: iterative shift-add multiplier, one multiplier bit per cycle.
//   clk, rst : clock, synchronous active-high reset (aborts a running multiply)
//   start    : load operands a/b and begin; ignored while not idle by the caller
//   a, b     : WIDTH-bit unsigned operands
//   done     : high during the cycle that processes the last multiplier bit
//   product  : 2*WIDTH-bit result, complete on the edge where done is high
module exec_mul_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               run_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= CW'(WIDTH - 1);
      run_q    <= 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end
    end
  end

  assign done    = run_q && (cnt_q == '0);
  assign product = acc_q;

endmodule

// File: rtl/execution_pipe.sv
// execution_pipe: WIDTH-bit execute stage with valid/ready handshake.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : upstream handshake; accept = in_valid && in_ready
//   s0, rd_data, imm      : operand A, register operand B, immediate operand B
//   aluctr, s2ctr         : opcode, B select (0: rd_data, 1: imm)
//   we, rdest_r           : writeback controls passed through to we_r / rdest_rr
//   out_valid / out_ready : downstream handshake on the result slot
//   s2, zero_r, carry_r   : registered result and flags
//   busy                  : multi-cycle multiply in progress
// Build option: define EXEC_MUL_EN for the iterative multiplier on opcode 111;
// otherwise 111 passes operand B through in a single cycle and busy is 0.
module execution_pipe
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   rd_data,
  input  logic [WIDTH-1:0]   s0,
  input  logic [WIDTH-1:0]   imm,
  input  logic [2:0]         aluctr,
  input  logic               s2ctr,
  input  logic               we,
  input  logic [RADDR_W-1:0] rdest_r,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   s2,
  output logic               we_r,
  output logic [RADDR_W-1:0] rdest_rr,
  output logic               zero_r,
  output logic               carry_r,
  output logic               busy
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic               out_valid_q;
  logic [WIDTH-1:0]   s2_q;
  logic               we_r_q;
  logic [RADDR_W-1:0] rdest_rr_q;
  logic               zero_q;
  logic               carry_q;

  logic [WIDTH-1:0]   opb;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               slot_free;
  logic               release_slot;
  logic               accept;

  assign opb          = s2ctr ? imm : rd_data;
  assign slot_free    = !out_valid_q || out_ready;
  assign release_slot = out_valid_q && out_ready;
  assign accept       = in_valid && in_ready;

  // Extra MSB carries the carry-out (ADD) or borrow (SUB, set when A < B).
  always_comb begin
    sum_ext   = {1'b0, s0} + {1'b0, opb};
    diff_ext  = {1'b0, s0} - {1'b0, opb};
    alu_res   = opb;
    alu_carry = 1'b0;
    case (aluctr)
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
      end
      OP_AND:  alu_res = s0 & opb;
      OP_OR:   alu_res = s0 | opb;
      OP_XOR:  alu_res = s0 ^ opb;
      OP_SHL:  alu_res = s0 << opb[SHW-1:0];
      OP_SHR:  alu_res = s0 >> opb[SHW-1:0];
      default: alu_res = opb;  // OP_MUL pass-through when the multiplier is absent
    endcase
  end

`ifdef EXEC_MUL_EN

  exec_state_e        state_q;
  logic               we_hold_q;
  logic [RADDR_W-1:0] rdest_hold_q;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign mul_start = accept && (aluctr == OP_MUL);
  assign in_ready  = (state_q == StIdle) && slot_free;
  assign busy      = (state_q != StIdle);

  exec_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (s0),
    .b       (opb),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      out_valid_q  <= 1'b0;
      s2_q         <= '0;
      we_r_q       <= 1'b0;
      rdest_rr_q   <= '0;
      zero_q       <= 1'b0;
      carry_q      <= 1'b0;
      we_hold_q    <= 1'b0;
      rdest_hold_q <= '0;
    end else begin
      // Default: a consumed result empties the slot; later loads override this.
      if (release_slot) begin
        out_valid_q <= 1'b0;
        we_r_q      <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (aluctr == OP_MUL) begin
              state_q      <= StMul;
              we_hold_q    <= we;
              rdest_hold_q <= rdest_r;
            end else begin
              out_valid_q <= 1'b1;
              s2_q        <= alu_res;
              carry_q     <= alu_carry;
              zero_q      <= (alu_res == '0);
              we_r_q      <= we;
              rdest_rr_q  <= rdest_r;
            end
          end
        end
        StMul: begin
          if (mul_done) begin
            state_q <= StWb;
          end
        end
        StWb: begin
          if (slot_free) begin
            out_valid_q <= 1'b1;
            s2_q        <= mul_prod[WIDTH-1:0];
            carry_q     <= |mul_prod[2*WIDTH-1:WIDTH];
            zero_q      <= (mul_prod[WIDTH-1:0] == '0);
            we_r_q      <= we_hold_q;
            rdest_rr_q  <= rdest_hold_q;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`else

  assign in_ready = slot_free;
  assign busy     = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      s2_q        <= '0;
      we_r_q      <= 1'b0;
      rdest_rr_q  <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      if (release_slot) begin
        out_valid_q <= 1'b0;
        we_r_q      <= 1'b0;
      end
      if (accept) begin
        out_valid_q <= 1'b1;
        s2_q        <= alu_res;
        carry_q     <= alu_carry;
        zero_q      <= (alu_res == '0);
        we_r_q      <= we;
        rdest_rr_q  <= rdest_r;
      end
    end
  end

`endif

  assign out_valid = out_valid_q;
  assign s2        = s2_q;
  assign we_r      = we_r_q;
  assign rdest_rr  = rdest_rr_q;
  assign zero_r    = zero_q;
  assign carry_r   = carry_q;

endmodule

// File: tb/tb_execution_pipe.sv
// Self-checking bench for execution_pipe (WIDTH=16, RADDR_W=4). Multiply
// sequences run only when EXEC_MUL_EN is defined for the build.
module tb_execution_pipe;

  localparam int unsigned W  = 16;
  localparam int unsigned RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  s0;
  logic [W-1:0]  imm;
  logic [2:0]    aluctr;
  logic          s2ctr;
  logic          we;
  logic [RW-1:0] rdest_r;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  s2;
  logic          we_r;
  logic [RW-1:0] rdest_rr;
  logic          zero_r;
  logic          carry_r;
  logic          busy;

  always #5 clk = ~clk;

  execution_pipe #(
    .WIDTH   (W),
    .RADDR_W (RW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rd_data   (rd_data),
    .s0        (s0),
    .imm       (imm),
    .aluctr    (aluctr),
    .s2ctr     (s2ctr),
    .we        (we),
    .rdest_r   (rdest_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s2        (s2),
    .we_r      (we_r),
    .rdest_rr  (rdest_rr),
    .zero_r    (zero_r),
    .carry_r   (carry_r),
    .busy      (busy)
  );

  typedef struct {
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sel;
    logic          we;
    logic [RW-1:0] rd;
    logic [W-1:0]  s2;
    logic          c;
    logic          z;
  } vec_t;

  typedef struct {
    logic [W-1:0]  s2;
    logic          c;
    logic          z;
    logic          we;
    logic [RW-1:0] rd;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, logic sel,
                              logic wen, logic [RW-1:0] rd, logic [W-1:0] r, logic c,
                              logic z);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.sel = sel; v.we = wen; v.rd = rd;
    v.s2 = r; v.c = c; v.z = z;
    return v;
  endfunction

  // Unselected B source gets the complement so a wrong mux shows up.
  task automatic drive(input vec_t v);
    s0      = v.a;
    aluctr  = v.op;
    s2ctr   = v.sel;
    we      = v.we;
    rdest_r = v.rd;
    if (v.sel) begin
      imm = v.b; rd_data = ~v.b;
    end else begin
      rd_data = v.b; imm = ~v.b;
    end
  endtask

  // Entered and left at posedge+2; returns after the accept edge.
  task automatic send(input vec_t v, input bit push);
    int n;
    exp_t e;
    drive(v);
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #3;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
    end else if (push) begin
      e.s2 = v.s2; e.c = v.c; e.z = v.z; e.we = v.we; e.rd = v.rd;
      sb.push_back(e);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  // Scoreboard: a result is compared in the cycle the slot is handed downstream.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h expected=none at %0t", s2, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("res_s2", s2, mon_e.s2);
        chk("res_carry", carry_r, mon_e.c);
        chk("res_zero", zero_r, mon_e.z);
        chk("res_we", we_r, mon_e.we);
        chk("res_rdest", rdest_rr, mon_e.rd);
        chk("res_busy", busy, 0);
      end
    end
  end

`ifdef EXEC_MUL_EN
  task automatic mul_seq(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input logic c);
    int k;
    bit bad;
    send(mk(3'b111, a, b, 1'b1, 1'b1, 4'h9, r, c, (r == '0)), 1'b1);
    k   = 0;
    bad = (!busy || in_ready);
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (!out_valid && (!busy || in_ready)) bad = 1'b1;
    end
    chk("mul_busy_hold", bad, 0);
    chk("mul_latency", k, W + 1);
    #1;
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs.push_back(mk(3'b000, 16'h7777, 16'h5555, 1'b0, 1'b1, 4'hA, 16'hCCCC, 1'b0, 1'b0));
    vecs.push_back(mk(3'b001, 16'h5555, 16'h7777, 1'b0, 1'b1, 4'h3, 16'hDDDE, 1'b1, 1'b0));
    vecs.push_back(mk(3'b001, 16'h1111, 16'h1111, 1'b1, 1'b0, 4'h5, 16'h0000, 1'b0, 1'b1));
    vecs.push_back(mk(3'b000, 16'hFFFF, 16'h0001, 1'b1, 1'b1, 4'hF, 16'h0000, 1'b1, 1'b1));
    vecs.push_back(mk(3'b010, 16'hF0F0, 16'h3C3C, 1'b0, 1'b1, 4'h1, 16'h3030, 1'b0, 1'b0));
    vecs.push_back(mk(3'b011, 16'hF0F0, 16'h0F00, 1'b1, 1'b0, 4'h2, 16'hFFF0, 1'b0, 1'b0));
    vecs.push_back(mk(3'b100, 16'hAAAA, 16'hFFFF, 1'b0, 1'b1, 4'h4, 16'h5555, 1'b0, 1'b0));
    vecs.push_back(mk(3'b101, 16'h0001, 16'h000F, 1'b0, 1'b0, 4'h6, 16'h8000, 1'b0, 1'b0));
    vecs.push_back(mk(3'b110, 16'h8000, 16'h0014, 1'b1, 1'b1, 4'h7, 16'h0800, 1'b0, 1'b0));
    vecs.push_back(mk(3'b001, 16'h0000, 16'h0001, 1'b0, 1'b1, 4'h8, 16'hFFFF, 1'b1, 1'b0));
`ifndef EXEC_MUL_EN
    vecs.push_back(mk(3'b111, 16'h1234, 16'hABCD, 1'b0, 1'b1, 4'hB, 16'hABCD, 1'b0, 1'b0));
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    rd_data = '0; s0 = '0; imm = '0; aluctr = '0; s2ctr = 1'b0; we = 1'b0; rdest_r = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s2", s2, 0);
    chk("rst_we_r", we_r, 0);
    chk("rst_rdest_rr", rdest_rr, 0);
    chk("rst_zero", zero_r, 0);
    chk("rst_carry", carry_r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #2;

    // Back-to-back table with the sink always ready.
    foreach (vecs[i]) send(vecs[i], 1'b1);
    @(posedge clk); #2;
    chk("release_out_valid", out_valid, 0);
    chk("release_we_r", we_r, 0);
    chk("release_s2_kept", s2, vecs[vecs.size() - 1].s2);

    // Backpressure: result held, second op waits for out_ready.
    out_ready = 1'b0;
    send(vecs[0], 1'b1);
    drive(vecs[1]);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_s2_stable", s2, 16'hCCCC);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    if (in_ready) begin
      mon_e.s2 = vecs[1].s2; mon_e.c = vecs[1].c; mon_e.z = vecs[1].z;
      mon_e.we = vecs[1].we; mon_e.rd = vecs[1].rd;
      sb.push_back(mon_e);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("bp_drained_valid", out_valid, 0);

`ifdef EXEC_MUL_EN
    mul_seq(16'h0003, 16'h0005, 16'h000F, 1'b0);
    mul_seq(16'hFFFF, 16'h0002, 16'hFFFE, 1'b1);
    @(posedge clk); #2;

    // Reset five cycles into a multiply; its result must never appear.
    send(mk(3'b111, 16'h0007, 16'h0009, 1'b1, 1'b1, 4'hC, 16'h003F, 1'b0, 1'b0), 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("mulrst_busy", busy, 0);
    chk("mulrst_out_valid", out_valid, 0);
    chk("mulrst_in_ready", in_ready, 1);
    repeat (25) @(posedge clk);
    #2;
    chk("mulrst_no_stale", out_valid, 0);
    send(vecs[0], 1'b1);
    @(posedge clk); #2;
`endif

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
